as_fifo: RTL and testbench

- Synchronous first-in/first-out buffer, 16 entries × 8 bits, with write and read ports sharing one clock.
- Provides full/empty status and a registered read-data output.
- Sits between a producer and a consumer; the verification environment drives it through the fifo_if bundle (clock, reset, we, re, data_in, data_out, full, empty).

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_if.sv | 34 +++
 rtl/fifo_mem.sv | 40 ++++
 rtl/as_fifo.sv | 64 ++++++
 tb/tb_as_fifo.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_pkg : shared sizes and types for the as_fifo block.  Rev 1.0
// ------------------------------------------------------------------
package fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH:0]   ptr_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage
`default_nettype wire

// File: rtl/fifo_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_if : producer/consumer bundle for as_fifo (level when FIFO_LEVEL_EN). Rev 1.0
// ------------------------------------------------------------------
interface fifo_if;
    import fifo_pkg::*;

    logic  we;
    logic  re;
    data_t data_in;
    data_t data_out;
    logic  full;
    logic  empty;
`ifdef FIFO_LEVEL_EN
    ptr_t  level;
`endif

    modport master (
        output we, re, data_in,
        input  data_out, full, empty
`ifdef FIFO_LEVEL_EN
        , input level
`endif
    );

    modport slave (
        input  we, re, data_in,
        output data_out, full, empty
`ifdef FIFO_LEVEL_EN
        , output level
`endif
    );
endinterface
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_mem : simple dual-port register array with registered read. Rev 1.0
// ------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = ADDR_WIDTH
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      wen_i,
    input  wire logic [MEM_ADDR_WIDTH-1:0] waddr_i,
    input  wire logic [MEM_DATA_WIDTH-1:0] wdata_i,
    input  wire logic                      ren_i,
    input  wire logic [MEM_ADDR_WIDTH-1:0] raddr_i,
    output logic      [MEM_DATA_WIDTH-1:0] rdata_o
);
    logic [MEM_DATA_WIDTH-1:0] mem_q [2**MEM_ADDR_WIDTH];
    logic [MEM_DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wen_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array keeps stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (ren_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/as_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// as_fifo : 16x8 synchronous FIFO; optional level output via FIFO_LEVEL_EN. Rev 1.0
// ------------------------------------------------------------------
module as_fifo
    import fifo_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    fifo_if.slave     bus
);
    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    logic wr_ok;
    logic rd_ok;

    // Same address with opposite wrap bits means the writer is a full lap ahead.
    assign bus.empty = (wptr_q == rptr_q);
    assign bus.full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                       (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

    assign wr_ok = bus.we & ~bus.full;
    assign rd_ok = bus.re & ~bus.empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) begin
            wptr_d = wptr_q + ptr_t'(1);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

`ifdef FIFO_LEVEL_EN
    assign bus.level = wptr_q - rptr_q;
`endif

    fifo_mem #(
        .MEM_DATA_WIDTH (DATA_WIDTH),
        .MEM_ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wen_i   (wr_ok),
        .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (bus.data_in),
        .ren_i   (rd_ok),
        .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (bus.data_out)
    );
endmodule
`default_nettype wire

// File: tb/tb_as_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_as_fifo : scoreboard bench for as_fifo (level checks when FIFO_LEVEL_EN). Rev 1.0
// ------------------------------------------------------------------
module tb_as_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] sb[$];
    logic [7:0] exp_dout = 8'h00;

    fifo_if dif ();

    as_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        bit wacc;
        bit racc;
        wacc = w && (sb.size() < 16);
        racc = r && (sb.size() > 0);
        dif.we      = w;
        dif.re      = r;
        dif.data_in = d;
        @(posedge clk);
        #1;
        if (racc) exp_dout = sb.pop_front();
        if (wacc) sb.push_back(d);
        dif.we = 1'b0;
        dif.re = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        exp_dout = 8'h00;
        #1;
        checks++; if (dif.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", dif.empty); end
        checks++; if (dif.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", dif.full); end
        checks++; if (dif.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", dif.data_out); end
`ifdef FIFO_LEVEL_EN
        checks++; if (dif.level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", dif.level); end
`endif
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h20 + 8'(i));
        drive(1'b0, 1'b1, 8'h00);
        checks++; if (dif.data_out !== 8'h20) begin errors++; $display("FAIL pre_async_dout got=%h want=20", dif.data_out); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        sb.delete();
        exp_dout = 8'h00;
        checks++; if (dif.empty !== 1'b1) begin errors++; $display("FAIL async_empty got=%b want=1", dif.empty); end
        checks++; if (dif.data_out !== 8'h00) begin errors++; $display("FAIL async_dout got=%h want=00", dif.data_out); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            checks++;
            if (dif.full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got=%b want=%b", i, dif.full, (i == 15)); end
        end
        checks++; if (dif.empty !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b want=0", dif.empty); end
        drive(1'b1, 1'b0, 8'hAA);
        checks++; if (dif.full !== 1'b1) begin errors++; $display("FAIL overflow_full got=%b want=1", dif.full); end
`ifdef FIFO_LEVEL_EN
        checks++; if (dif.level !== 5'd16) begin errors++; $display("FAIL fill_level got=%0d want=16", dif.level); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++;
            if (dif.data_out !== exp_dout || exp_dout !== 8'(i)) begin
                errors++; $display("FAIL drain_data[%0d] got=%h want=%h", i, dif.data_out, 8'(i));
            end
        end
        checks++; if (dif.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b want=1", dif.empty); end
        drive(1'b0, 1'b1, 8'h00);
        checks++; if (dif.data_out !== 8'h0F) begin errors++; $display("FAIL underflow_dout got=%h want=0f", dif.data_out); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++; if (dif.data_out !== exp_dout) begin errors++; $display("FAIL wrap_pre[%0d] got=%h want=%h", i, dif.data_out, exp_dout); end
        end
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'h50 + 8'(i));
        checks++; if (dif.full !== 1'b1) begin errors++; $display("FAIL wrap_full got=%b want=1", dif.full); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++; if (dif.data_out !== exp_dout) begin errors++; $display("FAIL wrap_data[%0d] got=%h want=%h", i, dif.data_out, exp_dout); end
        end
        checks++; if (dif.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b want=1", dif.empty); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] hold;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h60 + 8'(i));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 8'h70 + 8'(i));
            checks++;
            if (dif.data_out !== exp_dout || dif.empty !== 1'b0 || dif.full !== 1'b0) begin
                errors++; $display("FAIL simul_mid[%0d] got=%h/%b/%b want=%h/0/0", i, dif.data_out, dif.empty, dif.full, exp_dout);
            end
`ifdef FIFO_LEVEL_EN
            checks++; if (dif.level !== 5'd5) begin errors++; $display("FAIL simul_level[%0d] got=%0d want=5", i, dif.level); end
`endif
        end
        for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, 8'h80 + 8'(i));
        checks++; if (dif.full !== 1'b1) begin errors++; $display("FAIL simul_prefull got=%b want=1", dif.full); end
        drive(1'b1, 1'b1, 8'h99);
        checks++; if (dif.full !== 1'b0) begin errors++; $display("FAIL simul_full_drop got=%b want=0", dif.full); end
        checks++; if (dif.data_out !== 8'h73) begin errors++; $display("FAIL simul_full_dout got=%h want=73", dif.data_out); end
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++; if (dif.data_out !== exp_dout) begin errors++; $display("FAIL simul_drain[%0d] got=%h want=%h", i, dif.data_out, exp_dout); end
        end
        checks++; if (dif.empty !== 1'b1) begin errors++; $display("FAIL simul_drain_empty got=%b want=1", dif.empty); end
        hold = dif.data_out;
        drive(1'b1, 1'b1, 8'hC3);
        checks++; if (dif.empty !== 1'b0) begin errors++; $display("FAIL simul_empty_flag got=%b want=0", dif.empty); end
        checks++; if (dif.data_out !== 8'h8A || hold !== 8'h8A) begin errors++; $display("FAIL simul_empty_dout got=%h want=8a", dif.data_out); end
        drive(1'b0, 1'b1, 8'h00);
        checks++; if (dif.data_out !== 8'hC3) begin errors++; $display("FAIL simul_empty_write got=%h want=c3", dif.data_out); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++;
            if (dif.data_out !== 8'hC3 || dif.empty !== 1'b1 || dif.full !== 1'b0) begin
                errors++; $display("FAIL idle_empty[%0d] got=%h/%b/%b want=c3/1/0", i, dif.data_out, dif.empty, dif.full);
            end
        end
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'hB0 + 8'(i));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'hEE);
            checks++;
            if (dif.data_out !== 8'hC3 || dif.empty !== 1'b0 || dif.full !== 1'b1) begin
                errors++; $display("FAIL idle_full[%0d] got=%h/%b/%b want=c3/0/1", i, dif.data_out, dif.empty, dif.full);
            end
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            checks++; if (dif.data_out !== exp_dout) begin errors++; $display("FAIL idle_drain[%0d] got=%h want=%h", i, dif.data_out, exp_dout); end
        end
        checks++; if (dif.data_out !== 8'hBF) begin errors++; $display("FAIL idle_last got=%h want=bf", dif.data_out); end
    endtask

    initial begin
        dif.we      = 1'b0;
        dif.re      = 1'b0;
        dif.data_in = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
